// File: rtl/umi_regbank.sv
// Register bank behind the UMI register interface: ID, CTRL, W1C STATUS,
// free-running COUNT and scratch registers with byte-masked writes and registered reads.
module umi_regbank #(
  parameter int          AW = 64,
  parameter int          DW = 64,
  parameter int          N  = 8,
  parameter logic [63:0] ID = 64'h0
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [AW-1:0]   reg_addr,
  input  logic            reg_write,
  input  logic            reg_read,
  input  logic [7:0]      reg_cmd,
  input  logic [3:0]      reg_size,
  input  logic [4*DW-1:0] reg_wrdata,
  output logic [DW-1:0]   reg_rddata,
  input  logic [DW-1:0]   hw_event,
  output logic [DW-1:0]   ctrl,
  output logic            irq,
  output logic            addr_err
);

  localparam int          NB   = DW / 8;
  localparam int          B    = $clog2(NB);
  localparam int          LN   = $clog2(N);
  localparam logic [DW-1:0] ID_V = DW'(ID);

  logic [LN-1:0] idx;
  logic          oor;
  logic          wr_ok;
  logic          wr_ctrl;
  logic          wr_status;
  logic          wr_count;
  logic [DW-1:0] wdata;
  logic [DW-1:0] bmask;
  logic [DW-1:0] clr;
  logic [DW-1:0] rd_val;

  logic [DW-1:0] ctrl_q;
  logic [DW-1:0] status_q;
  logic [DW-1:0] count_q;
  logic [DW-1:0] status_d;
  logic [DW-1:0] count_d;
  logic [DW-1:0] scratch_q [4:N-1];

  // Command, upper write-data lanes and sub-word address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{reg_cmd, reg_wrdata, reg_addr};

  assign idx   = reg_addr[B +: LN];
  assign oor   = |(reg_addr >> (B + LN));
  assign wdata = reg_wrdata[DW-1:0];

  assign wr_ok     = reg_write & ~oor;
  assign wr_ctrl   = wr_ok && (idx == LN'(1));
  assign wr_status = wr_ok && (idx == LN'(2));
  assign wr_count  = wr_ok && (idx == LN'(3));

  // Byte k is written when the size covers it; sizes at or above the word width write all bytes.
  always_comb begin
    bmask = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if ((32'(reg_size) >= 32'(B)) || (k < (32'd1 << reg_size))) begin
        bmask[8*k +: 8] = '1;
      end
    end
  end

  assign clr      = wr_status ? (wdata & bmask) : '0;
  assign status_d = (status_q & ~clr) | hw_event;

  // A write replaces the increment; unmasked bytes keep the pre-increment value.
  always_comb begin
    count_d = count_q;
    if (ctrl_q[0]) begin
      count_d = count_q + 1'b1;
    end
    if (wr_count) begin
      count_d = (count_q & ~bmask) | (wdata & bmask);
    end
  end

  always_comb begin
    rd_val = '0;
    if (idx == LN'(0)) begin
      rd_val = ID_V;
    end else if (idx == LN'(1)) begin
      rd_val = ctrl_q;
    end else if (idx == LN'(2)) begin
      rd_val = status_q;
    end else if (idx == LN'(3)) begin
      rd_val = count_q;
    end else begin
      for (int unsigned i = 4; i < N; i++) begin
        if (idx == LN'(i)) begin
          rd_val = scratch_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ctrl_q     <= '0;
      status_q   <= '0;
      count_q    <= '0;
      reg_rddata <= '0;
      addr_err   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_q <= (ctrl_q & ~bmask) | (wdata & bmask);
      end
      status_q <= status_d;
      count_q  <= count_d;
      if (reg_read) begin
        reg_rddata <= oor ? '0 : rd_val;
      end
      addr_err <= (reg_read | reg_write) & oor;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 4; i < N; i++) begin
        scratch_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 4; i < N; i++) begin
        if (wr_ok && (idx == LN'(i))) begin
          scratch_q[i] <= (scratch_q[i] & ~bmask) | (wdata & bmask);
        end
      end
    end
  end

  assign ctrl = ctrl_q;
  assign irq  = |status_q;

endmodule

// File: doc/umi_regbank.md
Name: umi_regbank

Overview:
- Register bank downstream of the UMI register interface; consumes its reg_* request strobes and returns registered read data.
- Provides an ID register, a control register, a hardware-event status register (write-1-to-clear), a free-running cycle counter and general scratch registers.
- Read data is captured on the request cycle and held, matching the one-cycle-later response launch of the UMI register interface.

Parameters:
- AW, 64, address width of reg_addr
- DW, 64, register/data width; multiple of 8, 32 or 64
- N, 8, number of registers; power of 2, minimum 5
- ID, 64'h0, value returned by register 0 (truncated to DW)

Ports:
- clk  input  1  clock
- nreset  input  1  reset, asynchronous, active-low
- reg_addr  input  AW  byte address
- reg_write  input  1  write strobe (one cycle per request)
- reg_read  input  1  read strobe (one cycle per request)
- reg_cmd  input  8  command; ignored, all writes are plain writes
- reg_size  input  4  log2 of bytes to write
- reg_wrdata  input  4*DW  write data; only [DW-1:0] is used
- reg_rddata  output  DW  registered read data
- hw_event  input  DW  per-bit event pulses, set STATUS bits
- ctrl  output  DW  CTRL register contents
- irq  output  1  OR of all STATUS bits
- addr_err  output  1  one-cycle pulse on an access to an out-of-range index

Behaviour:
- Index decode:
  - B = log2(DW/8); idx = reg_addr[B +: log2(N)].
  - Bits below B are ignored.
  - Any nonzero reg_addr bit above B+log2(N)-1 makes the access out of range.
- Register map:
  - 0 ID: read-only, writes ignored.
  - 1 CTRL: RW.
  - 2 STATUS: W1C.
  - 3 COUNT: RW counter.
  - 4..N-1 SCRATCH: RW.
- Write masking:
  - Size s updates bytes [0 .. 2^s-1] of the target register; upper bytes are unchanged.
  - s >= B writes the full DW.
  - Mask applies identically to CTRL, COUNT and SCRATCH.
  - STATUS clear mask = wrdata AND byte-mask.
- Reset values: CTRL, STATUS, COUNT, SCRATCH, reg_rddata, addr_err all 0. irq 0 (derived from STATUS).
- Write timing: registers update on the clk edge ending the reg_write cycle.
- Read timing:
  - On reg_read, reg_rddata <= the selected register value, sampled before any same-edge update such as counter increment or status set.
  - reg_rddata holds until the next reg_read.
  - Latency: valid the cycle after reg_read.
- STATUS:
  - Each edge: STATUS <= (STATUS & ~clr) | hw_event.
  - If set and clear hit the same bit on the same edge, set wins.
- COUNT:
  - Increments by 1 each cycle while CTRL[0] = 1; wraps from all-ones to 0.
  - A write to COUNT on the same edge takes priority over the increment; the masked bytes load wrdata and unmasked bytes take the pre-increment value.
- irq = |STATUS (combinational from the register).
- Out of range:
  - Write is ignored.
  - Read sets reg_rddata <= 0.
  - addr_err = 1 for exactly the next cycle.
- reg_read and reg_write asserted together: write performed, read performed, read returns the pre-write value. Upstream never does this; the behaviour is defined for robustness.
- Reset mid-operation: all state returns to reset values immediately (async), with no pending read completion.

Test Plan:
- After reset: read idx0 (addr 0x0) -> reg_rddata = ID on the next cycle. Read idx1/2/3 -> 0. irq = 0.
- Write 0x1122334455667788 to addr 0x20 (idx4) with size 1, after a prior full write of all-ones -> read returns 0xFFFFFFFFFFFF7788.
- hw_event = 0x5 for one cycle -> STATUS = 0x5, irq = 1. Write 0x4 to addr 0x10 -> STATUS = 0x1. Write 0x1 with hw_event[0] = 1 on the same cycle -> STATUS = 0x1 (set wins).
- Write CTRL = 1 then COUNT = 0xFFFFFFFFFFFFFFFE -> counter wraps to 0 two cycles after the load edge. Read while counting returns the pre-increment value.
- Read addr 0x1000 (out of range, N = 8) -> reg_rddata = 0 and a single-cycle addr_err. A write there changes no register.
- Assert nreset low while CTRL = 1 and the counter is running -> ctrl, COUNT, reg_rddata and irq = 0 immediately. After release the counter stays 0.
